// File: rtl/eth_tx_ring_head.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_ring_head
// Brief    : TX ring head unit. Issues one start token at a time, collects
//            claimed tokens and slot_start appends, and queues their headers
//            for the MAC. Optional macro ETH_TX_RING_STATS_EN enables counters.
// Revision : 1.0 - initial release
// ============================================================================

package eth_tx_ring_pkg;

    typedef enum logic [1:0] {
        tx_none        = 2'd0,
        tx_start_empty = 2'd1,
        tx_start       = 2'd2,
        slot_start     = 2'd3
    } eth_tx_ring_stype_t;

    typedef struct packed {
        logic [7:0]  pid;
        logic [15:0] seqnum;
        logic [7:0]  ptype;
    } eth_tx_hdr_t;

    typedef struct packed {
        eth_tx_hdr_t header;
        logic [31:0] data;
    } eth_tx_msg_t;

    typedef struct packed {
        eth_tx_ring_stype_t stype;
        eth_tx_msg_t        msg;
    } eth_tx_ring_data_type;

    localparam int         HDR_W            = $bits(eth_tx_hdr_t);
    localparam logic [7:0] TMPID            = 8'h2A;
    localparam logic [7:0] ACK_PACKET_TYPE  = 8'h01;
    localparam logic [7:0] NACK_PACKET_TYPE = 8'h02;

endpackage

module eth_tx_ring_head
    import eth_tx_ring_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int TOKEN_GAP    = 8,
    parameter int RING_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  eth_tx_ring_data_type tx_ring_in,
    output eth_tx_ring_data_type tx_ring_out,
    output logic                 hdr_valid,
    input  logic                 hdr_ready,
    output logic [HDR_W-1:0]     hdr_out,
    output logic                 ring_busy,
    output logic                 timeout_pulse,
    output logic [15:0]          stat_tokens,
    output logic [15:0]          stat_hdrs,
    output logic [15:0]          stat_timeouts,
    output logic [15:0]          stat_drops
);

    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_gap_w = $clog2(TOKEN_GAP + 1);

    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(TOKEN_GAP - 1);
    localparam logic [7:0]         c_to_last  = 8'(RING_TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_room2    = c_cnt_w'(FIFO_DEPTH - 2);

    localparam logic [1:0] RH_GAP   = 2'd0;
    localparam logic [1:0] RH_ISSUE = 2'd1;
    localparam logic [1:0] RH_WAIT  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [c_gap_w-1:0]   gap_q, gap_d;
    logic [7:0]           to_q, to_d;
    logic                 busy_q, busy_d;
    logic                 pulse_q, pulse_d;
    eth_tx_ring_data_type ring_out_q, ring_out_d;
    eth_tx_hdr_t          mem_q [FIFO_DEPTH];
    eth_tx_hdr_t          mem_d [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic [HDR_W-1:0]     hdr_q, hdr_d;

    logic       w_gap_last, w_room2, w_tok_back, w_slot, w_expire;
    logic [7:0] w_to_inc;
    logic       w_ring_push, w_push, w_pop, w_drop, w_issue, w_timeout;
    logic       w_unused;

    assign w_gap_last = (gap_q == c_gap_last);
    assign w_room2    = (cnt_q <= c_room2);
    assign w_tok_back = (tx_ring_in.stype == tx_start_empty) || (tx_ring_in.stype == tx_start);
    assign w_slot     = (tx_ring_in.stype == slot_start);
    assign w_to_inc   = to_q + 8'd1;
    assign w_expire   = !w_tok_back && (w_to_inc == c_to_last);

    // State register and datapath flops
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= RH_GAP;
            gap_q      <= '0;
            to_q       <= '0;
            busy_q     <= 1'b0;
            pulse_q    <= 1'b0;
            ring_out_q <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            hdr_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            to_q       <= to_d;
            busy_q     <= busy_d;
            pulse_q    <= pulse_d;
            ring_out_q <= ring_out_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            hdr_q      <= hdr_d;
            mem_q      <= mem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RH_GAP:   if (w_gap_last && w_room2) state_d = RH_ISSUE;
            RH_ISSUE: state_d = RH_WAIT;
            RH_WAIT:  if (w_tok_back || w_expire) state_d = RH_GAP;
            default:  state_d = RH_GAP;
        endcase
    end

    always_comb begin
        gap_d       = gap_q;
        to_d        = to_q;
        busy_d      = busy_q;
        pulse_d     = 1'b0;
        ring_out_d  = '0;
        w_ring_push = w_slot;
        w_issue     = 1'b0;
        w_timeout   = 1'b0;
        unique case (state_q)
            RH_GAP: begin
                if (!w_gap_last) gap_d = gap_q + 1'b1;
            end
            RH_ISSUE: begin
                ring_out_d.stype = tx_start_empty;
                busy_d           = 1'b1;
                to_d             = '0;
                w_issue          = 1'b1;
            end
            RH_WAIT: begin
                to_d = w_to_inc;
                // Only a token seen here is live; elsewhere it is stale and dropped silently.
                if (tx_ring_in.stype == tx_start) w_ring_push = 1'b1;
                if (w_tok_back || w_expire) begin
                    busy_d    = 1'b0;
                    gap_d     = '0;
                    pulse_d   = w_expire;
                    w_timeout = w_expire;
                end
            end
            default: ;
        endcase
    end

    // Header FIFO; a pop frees the slot for a same-cycle push even when full.
    always_comb begin
        mem_d  = mem_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        w_pop  = (cnt_q != '0) && hdr_ready;
        w_push = w_ring_push && ((cnt_q != c_cnt_w'(FIFO_DEPTH)) || w_pop);
        w_drop = w_slot && !w_push;
        if (w_push) begin
            mem_d[wr_q] = tx_ring_in.msg.header;
            wr_d        = wr_q + 1'b1;
        end
        if (w_pop) rd_d = rd_q + 1'b1;
        unique case ({w_push, w_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        hdr_d = (cnt_d != '0) ? mem_d[rd_d] : '0;
    end

    assign tx_ring_out   = ring_out_q;
    assign hdr_valid     = (cnt_q != '0);
    assign hdr_out       = hdr_q;
    assign ring_busy     = busy_q;
    assign timeout_pulse = pulse_q;

`ifdef ETH_TX_RING_STATS_EN
    logic [15:0] st_tok_q, st_tok_d, st_hdr_q, st_hdr_d;
    logic [15:0] st_to_q, st_to_d, st_drop_q, st_drop_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    always_comb begin
        st_tok_d  = sat_inc(st_tok_q, w_issue);
        st_hdr_d  = sat_inc(st_hdr_q, w_push);
        st_to_d   = sat_inc(st_to_q, w_timeout);
        st_drop_d = sat_inc(st_drop_q, w_drop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_tok_q  <= '0;
            st_hdr_q  <= '0;
            st_to_q   <= '0;
            st_drop_q <= '0;
        end else begin
            st_tok_q  <= st_tok_d;
            st_hdr_q  <= st_hdr_d;
            st_to_q   <= st_to_d;
            st_drop_q <= st_drop_d;
        end
    end

    assign stat_tokens   = st_tok_q;
    assign stat_hdrs     = st_hdr_q;
    assign stat_timeouts = st_to_q;
    assign stat_drops    = st_drop_q;
`else
    assign stat_tokens   = '0;
    assign stat_hdrs     = '0;
    assign stat_timeouts = '0;
    assign stat_drops    = '0;
`endif

    assign w_unused = ^{tx_ring_in.msg.data, w_drop, w_issue, w_timeout};

endmodule

`default_nettype wire
